secret_pal_bus: RTL and testbench
=================================

Name: secret_pal_bus

Overview:
CPU-side bus stage for the Mr. Do protection PAL. It qualifies Z80 memory writes to the text-RAM window ($8800–$8FFF) and turns each one into a single-cycle PAL clock-enable strobe with the written byte. It services reads of the SECRE address ($9803) by capturing the PAL's registered output and holding it stable for the whole read cycle. It sits between the CPU bus decode and the protection PAL stage; the PAL's 8-bit output returns through this block onto the CPU read mux.

Parameters:
TRAM_LO, 16'h8800, lowest address that strobes the PAL.
TRAM_HI, 16'h8FFF, highest address that strobes the PAL.
SECRE_ADDR, 16'h9803, read address that enables the PAL output.
WR_FILTER, 2, consecutive cycles a write must persist before the strobe fires (1..7).

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous reset, active-high.
cpu_addr  in  16  Z80 address bus, synchronous to clk.
cpu_dout  in  8  Z80 write data.
cpu_mreq_n  in  1  Z80 memory request, active low.
cpu_wr_n  in  1  Z80 write strobe, active low.
cpu_rd_n  in  1  Z80 read strobe, active low.
pal_din  out  8  byte presented to the PAL, valid while pal_clk_en=1.
pal_clk_en  out  1  one-cycle PAL register clock enable.
pal_dout  in  8  PAL registered output; updates the cycle after pal_clk_en.
sec_dout  out  8  captured PAL value for the CPU read mux.
sec_oe  out  1  high while a SECRE read is being serviced; selects sec_dout on the mux.
rd_count  out  8  number of SECRE reads serviced; debug only.

Behaviour:
- Reset values: the FSM is in IDLE and armed=0. pal_din=0, pal_clk_en=0, sec_dout=0, sec_oe=0, rd_count=0.
- wr_cond = ~cpu_mreq_n & ~cpu_wr_n & (TRAM_LO ≤ cpu_addr ≤ TRAM_HI).
- rd_cond = ~cpu_mreq_n & ~cpu_rd_n & (cpu_addr == SECRE_ADDR).
- armed: cleared by reset. Set in the first cycle where both wr_cond=0 and rd_cond=0. Until armed=1 the FSM stays in IDLE and ignores all requests. This stops a bus cycle that straddles reset release from firing a partial strobe or read.
- FSM states are IDLE, WR_QUAL, WR_DONE and RD_HOLD.
- IDLE, armed, wr_cond=1: filt_cnt←1.
  - If WR_FILTER=1, go to WR_DONE, latch pal_din←cpu_dout and pulse pal_clk_en next cycle.
  - Otherwise go to WR_QUAL.
- IDLE, armed, rd_cond=1 with wr_cond=0: sec_dout←pal_dout, sec_oe←1, rd_count←rd_count+1, go to RD_HOLD.
- Simultaneous wr_cond and rd_cond in IDLE: the write wins and the read is dropped.
- WR_QUAL:
  - wr_cond=0 returns to IDLE with no strobe (glitch rejected).
  - Otherwise filt_cnt increments. On the cycle where filt_cnt reaches WR_FILTER, pal_din←cpu_dout (the data of that cycle), pal_clk_en←1 for exactly one cycle, and the FSM goes to WR_DONE.
- Latency: the strobe is asserted the cycle after the WR_FILTER-th consecutive wr_cond cycle. Default: the 3rd clock after the write begins.
- WR_DONE: pal_clk_en=0. Stay until wr_cond=0, then go to IDLE. There is exactly one strobe per CPU write regardless of its length. rd_cond is ignored in this state.
- RD_HOLD: sec_dout is frozen, even if pal_dout changes. When rd_cond=0, sec_oe←0 and go to IDLE. sec_dout keeps its last value after sec_oe drops.
- rd_count wraps 8'hFF→8'h00.
- Back-to-back writes: a second strobe is only possible after wr_cond has dropped for at least one cycle (WR_DONE→IDLE).
- Address change mid-write to outside the window: wr_cond drops. In WR_QUAL this aborts with no strobe; in WR_DONE it returns to IDLE.
- Reset mid-operation:
  - In-flight filtering is discarded and any pending strobe is cancelled.
  - sec_oe drops in the cycle after reset is sampled.
  - The block then requires a disarmed-then-armed idle cycle before the next request.
- Address comparisons are unsigned 16-bit. The window bounds are inclusive.

Test Plan:
- Reset, then a write of $A5 to $8800 held 4 cycles → one pal_clk_en pulse, 3rd cycle after the write starts, pal_din=$A5; no further pulse while wr_n stays low.
- A 1-cycle wr_n glitch to $8C00, WR_FILTER=2 → no pal_clk_en; the FSM returns to IDLE.
- Writes to $87FF and $9000 for 5 cycles each → no strobe. Writes to $8FFF → strobe.
- Drive pal_dout=$7C, then read $9803 for 4 cycles while pal_dout changes to $FF mid-read → sec_oe=1 from cycle 2 to the cycle after rd_n rises, sec_dout stays $7C, rd_count=1.
- Assert reset while a write to $8800 is held, release reset with the write still active → no strobe until wr_n rises and a fresh write occurs.
- 256 consecutive $9803 reads → rd_count wraps to $00. A read of $9802 → sec_oe stays 0.

Source files
------------

// File: rtl/secret_pal_bus.sv
`default_nettype none
// ============================================================================
// Module   : secret_pal_bus
// Purpose  : CPU-side bus stage for the Mr. Do protection PAL. It turns text-RAM
//            writes into PAL clock strobes and captures PAL output for SECRE reads.
// Revision : 1.0 - initial release
// ============================================================================
module secret_pal_bus #(
    parameter logic [15:0] TRAM_LO    = 16'h8800,
    parameter logic [15:0] TRAM_HI    = 16'h8FFF,
    parameter logic [15:0] SECRE_ADDR = 16'h9803,
    parameter int          WR_FILTER  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_mreq_n,
    input  logic        cpu_wr_n,
    input  logic        cpu_rd_n,
    output logic [7:0]  pal_din,
    output logic        pal_clk_en,
    input  logic [7:0]  pal_dout,
    output logic [7:0]  sec_dout,
    output logic        sec_oe,
    output logic [7:0]  rd_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_QUAL = 2'd1,
        ST_WR_DONE = 2'd2,
        ST_RD_HOLD = 2'd3
    } state_t;

    localparam logic [2:0] c_FILT = WR_FILTER[2:0];

    state_t     r_state;
    logic       r_armed;
    logic [2:0] r_filt_cnt;

    logic       w_in_win;
    logic       w_wr_cond;
    logic       w_rd_cond;

    assign w_in_win  = (cpu_addr >= TRAM_LO) && (cpu_addr <= TRAM_HI);
    assign w_wr_cond = ~cpu_mreq_n & ~cpu_wr_n & w_in_win;
    assign w_rd_cond = ~cpu_mreq_n & ~cpu_rd_n & (cpu_addr == SECRE_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_armed    <= 1'b0;
            r_filt_cnt <= 3'd0;
            pal_din    <= 8'h00;
            pal_clk_en <= 1'b0;
            sec_dout   <= 8'h00;
            sec_oe     <= 1'b0;
            rd_count   <= 8'h00;
        end else begin
            pal_clk_en <= 1'b0;

            // A bus cycle already in progress at reset release must end first.
            if (!w_wr_cond && !w_rd_cond) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_armed) begin
                        if (w_wr_cond) begin
                            r_filt_cnt <= 3'd1;
                            if (c_FILT == 3'd1) begin
                                pal_din    <= cpu_dout;
                                pal_clk_en <= 1'b1;
                                r_state    <= ST_WR_DONE;
                            end else begin
                                r_state    <= ST_WR_QUAL;
                            end
                        end else if (w_rd_cond) begin
                            sec_dout <= pal_dout;
                            sec_oe   <= 1'b1;
                            rd_count <= rd_count + 8'd1;
                            r_state  <= ST_RD_HOLD;
                        end
                    end
                end

                ST_WR_QUAL: begin
                    if (!w_wr_cond) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_filt_cnt <= r_filt_cnt + 3'd1;
                        if ((r_filt_cnt + 3'd1) == c_FILT) begin
                            pal_din    <= cpu_dout;
                            pal_clk_en <= 1'b1;
                            r_state    <= ST_WR_DONE;
                        end
                    end
                end

                ST_WR_DONE: begin
                    if (!w_wr_cond) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_RD_HOLD: begin
                    if (!w_rd_cond) begin
                        sec_oe  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_secret_pal_bus.sv
`default_nettype none
// ============================================================================
// Module   : tb_secret_pal_bus
// Purpose  : Directed self-checking bench for secret_pal_bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_secret_pal_bus;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_mreq_n;
    logic        cpu_wr_n;
    logic        cpu_rd_n;
    logic [7:0]  pal_din;
    logic        pal_clk_en;
    logic [7:0]  pal_dout;
    logic [7:0]  sec_dout;
    logic        sec_oe;
    logic [7:0]  rd_count;

    int checks = 0;
    int errors = 0;

    secret_pal_bus dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_mreq_n (cpu_mreq_n),
        .cpu_wr_n   (cpu_wr_n),
        .cpu_rd_n   (cpu_rd_n),
        .pal_din    (pal_din),
        .pal_clk_en (pal_clk_en),
        .pal_dout   (pal_dout),
        .sec_dout   (sec_dout),
        .sec_oe     (sec_oe),
        .rd_count   (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        cpu_mreq_n = 1'b1;
        cpu_wr_n   = 1'b1;
        cpu_rd_n   = 1'b1;
        cpu_addr   = 16'h0000;
        cpu_dout   = 8'h00;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        cpu_mreq_n = 1'b0;
        cpu_wr_n   = 1'b0;
        cpu_rd_n   = 1'b1;
        cpu_addr   = a;
        cpu_dout   = d;
    endtask

    task automatic bus_read(input logic [15:0] a);
        cpu_mreq_n = 1'b0;
        cpu_wr_n   = 1'b1;
        cpu_rd_n   = 1'b0;
        cpu_addr   = a;
    endtask

    task automatic test_reset();
        bus_idle();
        pal_dout = 8'h00;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (pal_clk_en !== 1'b0) begin
            errors++; $display("FAIL reset_pal_clk_en: got %b expected 0", pal_clk_en);
        end
        checks++;
        if (pal_din !== 8'h00) begin
            errors++; $display("FAIL reset_pal_din: got %h expected 00", pal_din);
        end
        checks++;
        if (sec_dout !== 8'h00) begin
            errors++; $display("FAIL reset_sec_dout: got %h expected 00", sec_dout);
        end
        checks++;
        if (sec_oe !== 1'b0) begin
            errors++; $display("FAIL reset_sec_oe: got %b expected 0", sec_oe);
        end
        checks++;
        if (rd_count !== 8'h00) begin
            errors++; $display("FAIL reset_rd_count: got %h expected 00", rd_count);
        end
    endtask

    task automatic test_write_basic();
        bus_write(16'h8800, 8'hA5);
        tick();
        checks++;
        if (pal_clk_en !== 1'b0) begin
            errors++; $display("FAIL wr_early_strobe: got %b expected 0", pal_clk_en);
        end
        tick();
        checks++;
        if (pal_clk_en !== 1'b1) begin
            errors++; $display("FAIL wr_strobe: got %b expected 1", pal_clk_en);
        end
        checks++;
        if (pal_din !== 8'hA5) begin
            errors++; $display("FAIL wr_pal_din: got %h expected a5", pal_din);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus_idle();
            tick();
            checks++;
            if (pal_clk_en !== 1'b0) begin
                errors++; $display("FAIL wr_single_strobe[%0d]: got %b expected 0", i, pal_clk_en);
            end
        end
    endtask

    task automatic test_glitch();
        int strobes = 0;
        bus_write(16'h8C00, 8'h33);
        tick();
        bus_idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pal_clk_en === 1'b1) strobes++;
        end
        checks++;
        if (strobes !== 0) begin
            errors++; $display("FAIL glitch_strobes: got %0d expected 0", strobes);
        end
        checks++;
        if (pal_din !== 8'hA5) begin
            errors++; $display("FAIL glitch_pal_din: got %h expected a5", pal_din);
        end
        // A subsequent normal write must still work, proving return to IDLE.
        bus_write(16'h8C00, 8'h3C);
        tick();
        tick();
        checks++;
        if (pal_clk_en !== 1'b1 || pal_din !== 8'h3C) begin
            errors++; $display("FAIL glitch_recover: got en=%b din=%h expected en=1 din=3c", pal_clk_en, pal_din);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_window();
        int strobes = 0;
        bus_write(16'h87FF, 8'h11);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pal_clk_en === 1'b1) strobes++;
        end
        bus_idle();
        tick();
        bus_write(16'h9000, 8'h22);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pal_clk_en === 1'b1) strobes++;
        end
        bus_idle();
        tick();
        checks++;
        if (strobes !== 0) begin
            errors++; $display("FAIL window_outside_strobes: got %0d expected 0", strobes);
        end
        bus_write(16'h8FFF, 8'h5A);
        tick();
        tick();
        checks++;
        if (pal_clk_en !== 1'b1 || pal_din !== 8'h5A) begin
            errors++; $display("FAIL window_top_edge: got en=%b din=%h expected en=1 din=5a", pal_clk_en, pal_din);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_read();
        pal_dout = 8'h7C;
        bus_read(16'h9803);
        checks++;
        if (sec_oe !== 1'b0) begin
            errors++; $display("FAIL rd_oe_cycle1: got %b expected 0", sec_oe);
        end
        tick();
        checks++;
        if (sec_oe !== 1'b1 || sec_dout !== 8'h7C || rd_count !== 8'h01) begin
            errors++; $display("FAIL rd_capture: got oe=%b dout=%h cnt=%h expected oe=1 dout=7c cnt=01", sec_oe, sec_dout, rd_count);
        end
        pal_dout = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (sec_oe !== 1'b1 || sec_dout !== 8'h7C) begin
                errors++; $display("FAIL rd_hold[%0d]: got oe=%b dout=%h expected oe=1 dout=7c", i, sec_oe, sec_dout);
            end
        end
        bus_idle();
        tick();
        checks++;
        if (sec_oe !== 1'b0 || sec_dout !== 8'h7C || rd_count !== 8'h01) begin
            errors++; $display("FAIL rd_release: got oe=%b dout=%h cnt=%h expected oe=0 dout=7c cnt=01", sec_oe, sec_dout, rd_count);
        end
    endtask

    task automatic test_reset_mid_write();
        int strobes = 0;
        bus_write(16'h8800, 8'h11);
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pal_clk_en === 1'b1) strobes++;
        end
        checks++;
        if (strobes !== 0 || pal_din !== 8'h00) begin
            errors++; $display("FAIL rstw_no_strobe: got strobes=%0d din=%h expected 0 and 00", strobes, pal_din);
        end
        bus_idle();
        tick();
        bus_write(16'h8800, 8'h22);
        tick();
        tick();
        checks++;
        if (pal_clk_en !== 1'b1 || pal_din !== 8'h22) begin
            errors++; $display("FAIL rstw_fresh_write: got en=%b din=%h expected en=1 din=22", pal_clk_en, pal_din);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_reset_mid_read();
        pal_dout = 8'h44;
        bus_read(16'h9803);
        tick();
        checks++;
        if (sec_oe !== 1'b1 || sec_dout !== 8'h44) begin
            errors++; $display("FAIL rstr_pre: got oe=%b dout=%h expected oe=1 dout=44", sec_oe, sec_dout);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (sec_oe !== 1'b0 || rd_count !== 8'h00) begin
            errors++; $display("FAIL rstr_drop: got oe=%b cnt=%h expected oe=0 cnt=00", sec_oe, rd_count);
        end
        tick();
        checks++;
        if (sec_oe !== 1'b0) begin
            errors++; $display("FAIL rstr_unarmed: got oe=%b expected 0", sec_oe);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 255; i++) begin
            bus_read(16'h9803);
            tick();
            bus_idle();
            tick();
        end
        checks++;
        if (rd_count !== 8'hFF) begin
            errors++; $display("FAIL wrap_255: got %h expected ff", rd_count);
        end
        bus_read(16'h9803);
        tick();
        checks++;
        if (rd_count !== 8'h00 || sec_oe !== 1'b1) begin
            errors++; $display("FAIL wrap_256: got cnt=%h oe=%b expected cnt=00 oe=1", rd_count, sec_oe);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_bad_read();
        bus_read(16'h9802);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (sec_oe !== 1'b0 || rd_count !== 8'h00) begin
                errors++; $display("FAIL bad_read[%0d]: got oe=%b cnt=%h expected oe=0 cnt=00", i, sec_oe, rd_count);
            end
        end
        bus_idle();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        bus_idle();
        pal_dout = 8'h00;
        test_reset();
        test_write_basic();
        test_glitch();
        test_window();
        test_read();
        test_reset_mid_write();
        test_reset_mid_read();
        test_wrap();
        test_bad_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
